// File: rtl/ddr_rd_pkg.sv
// Shared types and widths for the DDR read-back streamer.
package ddr_rd_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SIZE_W = 24;
    localparam int unsigned WCNT_W = 26;
    localparam int unsigned WPTR_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ARWAIT,
        S_DRAIN
    } ar_state_e;

    // Number of 32-bit words touched by a non-empty byte range starting at byte offset ofs.
    function automatic logic [WCNT_W-1:0] span_words(input logic [1:0]        ofs,
                                                     input logic [SIZE_W-1:0] size);
        return ((WCNT_W'(ofs) + WCNT_W'(size) - WCNT_W'(1)) >> 2) + WCNT_W'(1);
    endfunction

endpackage

// File: rtl/ddr_rd_streamer_sfifo_fwft.sv
// First-word-fall-through synchronous FIFO; a word pushed in cycle N is at the head in N+1.
module sfifo_fwft #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_c_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;

endmodule

// File: rtl/ddr_rd_streamer.sv
// Reads a byte range from DDR with credit-limited AXI4 INCR bursts and streams
// exactly the requested bytes, LSB first, to the UART transmitter.
module ddr_rd_streamer
    import ddr_rd_pkg::*;
#(
    parameter int unsigned BURST_MAX  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic [31:0]       axi4_araddr,
    output logic [7:0]        axi4_arlen,
    output logic              axi4_arvalid,
    input  logic              axi4_arready,
    input  logic [31:0]       axi4_rdata,
    input  logic [1:0]        axi4_rresp,
    input  logic              axi4_rlast,
    input  logic              axi4_rvalid,
    output logic              axi4_rready,
    output logic [7:0]        tx_byte,
    output logic              tx_req,
    input  logic              tx_idle,
    output logic              busy,
    output logic              done,
    output logic              rd_err
);

    localparam int unsigned BEAT_W = $clog2(BURST_MAX) + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    ar_state_e         state_q, state_d;
    logic [WPTR_W-1:0] wptr_q, wptr_d;
    logic [WCNT_W-1:0] words_left_q, words_left_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0]  reserved_q, reserved_d;
    logic [SIZE_W-1:0] bytes_left_q, bytes_left_d;
    logic [1:0]        bsel_q, bsel_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              arvalid_q, arvalid_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              rready_q;
    logic              tx_req_q, tx_req_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_err_q, rd_err_d;

    logic              accept, issue, ar_hs, credit_ok, drain_ok;
    logic [WCNT_W-1:0] cmd_words, iss_words, to_bound;
    logic [WPTR_W-1:0] iss_wptr;
    logic [BEAT_W-1:0] beats_c;
    logic              fifo_push, fifo_pop, tx_fire;
    logic [31:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    assign accept    = cmd_valid && cmd_ready_q;
    assign ar_hs     = arvalid_q && axi4_arready;
    assign cmd_words = span_words(cmd_addr[1:0], cmd_size);
    assign drain_ok  = (bytes_left_q == '0) && !tx_req_q;

    // The first burst is sized from the command itself so AR goes out the cycle after accept.
    assign iss_wptr  = (state_q == S_IDLE) ? cmd_addr[ADDR_W-1:2] : wptr_q;
    assign iss_words = (state_q == S_IDLE) ? cmd_words : words_left_q;
    assign to_bound  = WCNT_W'(BURST_MAX) - WCNT_W'(iss_wptr % WPTR_W'(BURST_MAX));
    assign beats_c   = (iss_words < to_bound) ? BEAT_W'(iss_words) : BEAT_W'(to_bound);
    assign credit_ok = (32'(reserved_q) + 32'(beats_c)) <= 32'(FIFO_DEPTH);
    assign issue     = ((state_q == S_IDLE) && accept && (cmd_size != '0)) ||
                       ((state_q == S_ISSUE) && credit_ok);

    assign fifo_push = axi4_rvalid && rready_q;
    assign tx_fire   = (fifo_count != '0) && tx_idle && !tx_req_q && (bytes_left_q != '0);
    assign fifo_pop  = tx_fire && ((bsel_q == 2'd3) || (bytes_left_q == SIZE_W'(1)));

    sfifo_fwft #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (fifo_push),
        .wdata_i  (axi4_rdata),
        .pop_i    (fifo_pop),
        .head_c_o (fifo_head),
        .count_o  (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (issue) state_d = S_ARWAIT;
            S_ISSUE:  if (credit_ok) state_d = S_ARWAIT;
            S_ARWAIT: if (ar_hs) state_d = (words_left_q != WCNT_W'(beats_q)) ? S_ISSUE : S_DRAIN;
            S_DRAIN:  if (drain_ok) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE:   if (accept && (cmd_size == '0)) done_d = 1'b1;
            S_ARWAIT: if (axi4_arready) arvalid_d = 1'b0;
            S_DRAIN:  if (drain_ok) done_d = 1'b1;
            default:  ;
        endcase
        if (issue) begin
            arvalid_d = 1'b1;
            araddr_d  = {iss_wptr, 2'b00};
            arlen_d   = 8'(beats_c - BEAT_W'(1));
        end
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // Word/credit bookkeeping and the byte serializer.
    always_comb begin
        wptr_d       = wptr_q;
        words_left_d = words_left_q;
        beats_d      = beats_q;
        reserved_d   = reserved_q;
        bytes_left_d = bytes_left_q;
        bsel_d       = bsel_q;
        tx_req_d     = tx_req_q;
        tx_byte_d    = tx_byte_q;
        rd_err_d     = rd_err_q;
        if (accept) begin
            wptr_d       = cmd_addr[ADDR_W-1:2];
            words_left_d = cmd_words;
            bytes_left_d = cmd_size;
            bsel_d       = cmd_addr[1:0];
            rd_err_d     = 1'b0;
        end
        if (issue) begin
            beats_d = beats_c;
        end
        if (ar_hs) begin
            wptr_d       = wptr_q + WPTR_W'(beats_q);
            words_left_d = words_left_q - WCNT_W'(beats_q);
            reserved_d   = reserved_q + CNT_W'(beats_q);
        end
        if (fifo_pop) begin
            reserved_d = reserved_d - CNT_W'(1);
        end
        if (tx_req_q && !tx_idle) begin
            tx_req_d = 1'b0;
        end
        if (tx_fire) begin
            tx_byte_d    = fifo_head[{bsel_q, 3'b000} +: 8];
            tx_req_d     = 1'b1;
            bytes_left_d = bytes_left_q - SIZE_W'(1);
            bsel_d       = bsel_q + 2'd1;
        end
        if (fifo_push && (axi4_rresp != 2'b00)) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            words_left_q <= '0;
            beats_q      <= '0;
            reserved_q   <= '0;
            bytes_left_q <= '0;
            bsel_q       <= '0;
            cmd_ready_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            rready_q     <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_byte_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            words_left_q <= words_left_d;
            beats_q      <= beats_d;
            reserved_q   <= reserved_d;
            bytes_left_q <= bytes_left_d;
            bsel_q       <= bsel_d;
            cmd_ready_q  <= cmd_ready_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            rready_q     <= 1'b1;
            tx_req_q     <= tx_req_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_err_q     <= rd_err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign axi4_arvalid = arvalid_q;
    assign axi4_araddr  = araddr_q;
    assign axi4_arlen   = arlen_q;
    assign axi4_rready  = rready_q;
    assign tx_req       = tx_req_q;
    assign tx_byte      = tx_byte_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_err       = rd_err_q;

    // Credit is reserved before AR issue, so neither of these can fire on a legal slave.
    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !fifo_pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
    rlast_credit_a: assert property (@(posedge clk) disable iff (rst)
        (axi4_rvalid && axi4_rlast) |-> (reserved_q != '0));

endmodule

// File: tb/tb_ddr_rd_streamer.sv
// Directed bench for ddr_rd_streamer: AXI slave and UART models feed a byte/AR scoreboard.
module tb_ddr_rd_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [23:0] cmd_size;
    logic [31:0] axi4_araddr;
    logic [7:0]  axi4_arlen;
    logic        axi4_arvalid, axi4_arready;
    logic [31:0] axi4_rdata;
    logic [1:0]  axi4_rresp;
    logic        axi4_rlast, axi4_rvalid, axi4_rready;
    logic [7:0]  tx_byte;
    logic        tx_req, tx_idle;
    logic        busy, done, rd_err;

    always #5 clk = ~clk;

    ddr_rd_streamer #(.BURST_MAX(16), .FIFO_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .axi4_araddr(axi4_araddr), .axi4_arlen(axi4_arlen), .axi4_arvalid(axi4_arvalid),
        .axi4_arready(axi4_arready), .axi4_rdata(axi4_rdata), .axi4_rresp(axi4_rresp),
        .axi4_rlast(axi4_rlast), .axi4_rvalid(axi4_rvalid), .axi4_rready(axi4_rready),
        .tx_byte(tx_byte), .tx_req(tx_req), .tx_idle(tx_idle),
        .busy(busy), .done(done), .rd_err(rd_err)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { int unsigned w; int unsigned n; } burst_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q [$];
    ar_t         ar_exp [$];
    burst_t      bq [$];
    logic [31:0] mem [int unsigned];
    bit          err_inject = 1'b0;
    bit          uart_hold  = 1'b0;
    int          ar_cnt = 0, beat_cnt = 0, nbytes = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Unwritten words hold their own byte addresses, so byte at address a reads a[7:0].
    function automatic logic [31:0] word_at(input int unsigned w);
        if (mem.exists(w)) return mem[w];
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        ar_exp.push_back(a);
    endtask

    task automatic push_pat(input logic [31:0] addr, input int size);
        for (int i = 0; i < size; i++) exp_q.push_back(8'(addr + 32'(i)));
    endtask

    // AXI4 read slave: arready stalls one cycle in three, R beats pause one cycle in five.
    initial begin
        burst_t b;
        ar_t    e;
        axi4_arready = 1'b0;
        axi4_rvalid  = 1'b0;
        axi4_rdata   = '0;
        axi4_rresp   = '0;
        axi4_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                axi4_arready = 1'b0;
                axi4_rvalid  = 1'b0;
            end else begin
                if (bq.size() != 0 && (cyc % 5) != 4) begin
                    b = bq.pop_front();
                    axi4_rvalid = 1'b1;
                    axi4_rdata  = word_at(b.w);
                    axi4_rresp  = err_inject ? 2'd2 : 2'd0;
                    axi4_rlast  = (b.n == 1);
                    beat_cnt++;
                    b.w++;
                    b.n--;
                    if (b.n != 0) bq.push_front(b);
                end else begin
                    axi4_rvalid = 1'b0;
                    axi4_rlast  = 1'b0;
                end
                axi4_arready = (cyc % 3) != 1;
                if (axi4_arvalid && axi4_arready) begin
                    if (ar_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ar_unexpected: araddr 0x%0h arlen %0d with none expected",
                                 axi4_araddr, axi4_arlen);
                    end else begin
                        e = ar_exp.pop_front();
                        chk("araddr", axi4_araddr, e.addr);
                        chk("arlen", 32'(axi4_arlen), 32'(e.len));
                    end
                    b.w = axi4_araddr >> 2;
                    b.n = 32'(axi4_arlen) + 1;
                    bq.push_back(b);
                    ar_cnt++;
                end
            end
        end
    end

    // UART model and byte monitor: each request starts a 4-cycle frame.
    initial begin
        int ucnt;
        logic [7:0] e;
        ucnt    = 0;
        tx_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_idle = 1'b1;
                ucnt    = 0;
            end else if (uart_hold) begin
                tx_idle = 1'b0;
            end else if (ucnt != 0) begin
                ucnt--;
                if (ucnt == 0) tx_idle = 1'b1;
            end else if (tx_req && tx_idle) begin
                nbytes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte_unexpected: got 0x%0h with none expected", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_byte), 32'(e));
                end
                tx_idle = 1'b0;
                ucnt    = 3;
            end else begin
                tx_idle = 1'b1;
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] addr, input logic [23:0] size);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_size  = size;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rd_err_clear_on_accept", 32'(rd_err), 0);
        if (size == 0) begin
            chk("done_at_accept_plus1", 32'(done), 1);
            chk("arvalid_size0", 32'(axi4_arvalid), 0);
        end else begin
            chk("cmd_ready_fall", 32'(cmd_ready), 0);
            chk("busy_after_accept", 32'(busy), 1);
            chk("arvalid_at_accept_plus1", 32'(axi4_arvalid), 1);
        end
    endtask

    task automatic wait_done(input int bound);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            @(negedge clk);
            got = done;
            n++;
        end
        chk("done_seen", 32'(got), 1);
        chk("bytes_outstanding", 32'(exp_q.size()), 0);
        chk("ar_outstanding", 32'(ar_exp.size()), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;
        int   n0, k;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_arvalid", 32'(axi4_arvalid), 0);
        chk("rst_rready", 32'(axi4_rready), 0);
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_busy_done_err", {29'd0, busy, done, rd_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 1);
        chk("rready_after_rst", 32'(axi4_rready), 1);

        // One aligned word.
        mem[32'h40] = 32'h4433_2211;
        push_ar(32'h100, 8'd0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        issue_cmd(32'h100, 24'd4);
        wait_done(500);

        // Unaligned start spanning two words.
        mem[32'h40] = 32'hDDCC_BBAA;
        mem[32'h41] = 32'h8877_6655;
        push_ar(32'h100, 8'd1);
        exp_q.push_back(8'hCC); exp_q.push_back(8'hDD); exp_q.push_back(8'h55);
        exp_q.push_back(8'h66); exp_q.push_back(8'h77);
        issue_cmd(32'h102, 24'd5);
        wait_done(500);
        mem.delete();

        // Single byte at the last lane of a word.
        push_ar(32'h0, 8'd0);
        exp_q.push_back(8'h03);
        issue_cmd(32'h3, 24'd1);
        wait_done(500);

        // 16-word boundary split: 2 + 16 + 16 + 16 words.
        push_ar(32'h38, 8'd1);
        push_ar(32'h40, 8'd15);
        push_ar(32'h80, 8'd15);
        push_ar(32'hC0, 8'd15);
        push_pat(32'h38, 200);
        issue_cmd(32'h38, 24'd200);
        wait_done(5000);

        // UART stalled: only 32 words of credit may be requested.
        uart_hold = 1'b1;
        ar_cnt    = 0;
        beat_cnt  = 0;
        push_ar(32'h00, 8'd15);
        push_ar(32'h40, 8'd15);
        push_ar(32'h80, 8'd15);
        push_ar(32'hC0, 8'd15);
        push_pat(32'h0, 256);
        issue_cmd(32'h0, 24'd256);
        repeat (1000) @(negedge clk);
        chk("ar_count_while_stalled", 32'(ar_cnt), 2);
        chk("beats_while_stalled", 32'(beat_cnt), 32);
        chk("no_tx_req_while_stalled", 32'(tx_req), 0);
        uart_hold = 1'b0;
        wait_done(5000);

        // Error response on every beat; bytes still delivered.
        err_inject = 1'b1;
        push_ar(32'h200, 8'd1);
        push_pat(32'h200, 8);
        issue_cmd(32'h200, 24'd8);
        wait_done(500);
        err_inject = 1'b0;
        chk("rd_err_sticky", 32'(rd_err), 1);

        // Zero-length request clears rd_err and produces no traffic.
        issue_cmd(32'h40, 24'd0);
        quiet = 1'b0;
        repeat (5) begin
            @(negedge clk);
            quiet = quiet | axi4_arvalid | tx_req | busy;
        end
        chk("size0_quiet", 32'(quiet), 0);

        // Reset in the middle of a transfer.
        err_inject = 1'b1;
        push_ar(32'h10, 8'd11);
        push_ar(32'h40, 8'd3);
        push_pat(32'h10, 64);
        issue_cmd(32'h10, 24'd64);
        n0 = nbytes;
        k  = 0;
        while (nbytes < n0 + 3 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("bytes_before_reset", 32'(nbytes >= n0 + 3), 1);
        chk("rd_err_before_reset", 32'(rd_err), 1);
        rst = 1'b1;
        #1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 0);
        chk("midrst_ar", {axi4_araddr[23:0], axi4_arlen}, 0);
        chk("midrst_arvalid_rready", {30'd0, axi4_arvalid, axi4_rready}, 0);
        chk("midrst_tx", {23'd0, tx_req, tx_byte}, 0);
        chk("midrst_busy_done_err", {29'd0, busy, done, rd_err}, 0);
        exp_q.delete();
        ar_exp.delete();
        bq.delete();
        err_inject = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fresh request after reset.
        push_ar(32'h104, 8'd1);
        push_pat(32'h104, 6);
        issue_cmd(32'h104, 24'd6);
        wait_done(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
